// File: rtl/seg_display_scan.sv
// seg_display_scan: 4-digit common-anode seven-segment scanner with frame-synchronous
// double buffering, anti-ghosting guard interval and per-digit blink.
module seg_display_scan #(
    parameter int REFRESH_DIV  = 100000,
    parameter int GUARD        = 500,
    parameter int BLINK_FRAMES = 125
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] digits,
    input  logic [3:0]  blank,
    input  logic [3:0]  dp,
    input  logic [3:0]  blink,
    output logic [7:0]  seg,
    output logic [3:0]  an,
    output logic        frame_start
);
    localparam int CW = $clog2(REFRESH_DIV);
    localparam int FW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] CNT_GUARD = CW'(GUARD);
    localparam logic [FW-1:0] FCNT_LAST = FW'(BLINK_FRAMES - 1);
    localparam logic [6:0] HEX [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic [FW-1:0] fcnt;
    logic          bph;
    logic [27:0]   pendBuf;
    logic          pendValid;
    logic [15:0]   actDigits;
    logic [3:0]    actBlank;
    logic [3:0]    actDp;
    logic [3:0]    actBlink;
    logic          frameWrap;
    logic          slotEnd;
    logic          frameEnd;
    logic          inGuard;
    logic          dark;
    logic [3:0]    nib;
    logic [7:0]    segNext;
    logic [3:0]    anNext;

    always_comb begin
        slotEnd  = cnt == CNT_LAST;
        frameEnd = slotEnd && idx == 2'd3;
        inGuard  = cnt < CNT_GUARD;
        nib      = actDigits[{idx, 2'b00} +: 4];
        dark     = actBlank[idx] | (actBlink[idx] & bph);
        segNext  = (inGuard | dark) ? 8'hFF : {~actDp[idx], HEX[nib]};
        anNext   = inGuard ? 4'hF : ~(4'b0001 << idx);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            idx         <= '0;
            fcnt        <= '0;
            bph         <= 1'b0;
            pendBuf     <= '0;
            pendValid   <= 1'b0;
            actDigits   <= '0;
            actBlank    <= 4'hF;
            actDp       <= '0;
            actBlink    <= '0;
            frameWrap   <= 1'b0;
            frame_start <= 1'b0;
            seg         <= 8'hFF;
            an          <= 4'hF;
        end else begin
            cnt         <= slotEnd ? '0 : cnt + 1'b1;
            idx         <= slotEnd ? idx + 2'd1 : idx;
            frameWrap   <= frameEnd;
            frame_start <= frameWrap;
            seg         <= segNext;
            an          <= anNext;
            if (frameEnd) begin
                if (pendValid)
                    {actDigits, actBlank, actDp, actBlink} <= pendBuf;
                fcnt <= fcnt == FCNT_LAST ? '0 : fcnt + 1'b1;
                if (fcnt == FCNT_LAST)
                    bph <= ~bph;
            end
            // A load on the boundary edge re-arms pending after the old contents commit
            if (load) begin
                pendBuf   <= {digits, blank, dp, blink};
                pendValid <= 1'b1;
            end else if (frameEnd) begin
                pendValid <= 1'b0;
            end
        end
    end
endmodule

// File: doc/seg_display_scan.md
# seg_display_scan

Time-multiplexed driver for the 4-digit common-anode seven-segment display; it is the output-side counterpart of the keypad scanner and button debouncers. Game logic presents four hex digits plus per-digit blank, decimal-point and blink masks with a `load` strobe. The block double-buffers them so updates take effect only at frame boundaries, which prevents tearing. It scans one digit at a time with an anti-ghosting guard interval and drives the board-level `seg`/`an` pins directly.

## Interface
- `REFRESH_DIV`, 100000: clock cycles per digit slot (1 ms at 100 MHz); must be ≥ 2.
- `GUARD`, 500: cycles at the start of each slot with all anodes off; must be < `REFRESH_DIV`.
- `BLINK_FRAMES`, 125: frames per blink half-period; must be ≥ 1.
- `clk` input 1: system clock; all logic on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `load` input 1: single-cycle strobe that captures `digits`/`blank`/`dp`/`blink` into the pending buffer.
- `digits` input 16: four hex nibbles; `digits[4i+3:4i]` is digit i. Digit 0 is rightmost and drives `an[0]`.
- `blank` input 4: bit i = 1 forces digit i dark, including its DP.
- `dp` input 4: bit i = 1 lights the decimal point of digit i.
- `blink` input 4: bit i = 1 blanks digit i during the blink-off phase.
- `seg` output 8: active-low cathodes. `seg[0]`..`seg[6]` = a..g, `seg[7]` = DP.
- `an` output 4: active-low anodes; at most one bit is low at any time.
- `frame_start` output 1: one-cycle pulse when a new frame begins.

## Operation
- State:
  - Prescaler `cnt` runs 0..`REFRESH_DIV`-1.
  - Slot index `idx` runs 0..3.
  - Frame counter `fcnt` runs 0..`BLINK_FRAMES`-1.
  - Blink phase `bph`: 0 = on, 1 = off.
  - Pending buffer plus `pend_valid`.
  - Active (displayed) buffer.
- `load`: the pending buffer takes the input values and `pend_valid` is set to 1. Repeated loads before a commit overwrite the pending buffer; the last one wins.
- Slot advance: when `cnt == REFRESH_DIV-1`, `cnt` goes to 0 and `idx` goes to (`idx`+1) mod 4. Otherwise `cnt` increments.
- Frame boundary: the slot advance where `idx` wraps 3→0. On this edge:
  - If `pend_valid` = 1, active buffer ← pending buffer and `pend_valid` ← 0.
  - `fcnt` increments. When `fcnt` = `BLINK_FRAMES`-1, `fcnt` ← 0 and `bph` toggles.
- Simultaneous `load` and frame boundary: the old pending contents commit, the new load data becomes pending (`pend_valid` stays 1), and it displays from the next frame.
- Digit i is dark when: `blank[i]`, or (`blink[i]` and `bph` = 1), using the active buffer. A dark digit gives `seg` = 8'hFF.
- Hex encoding in `seg[6:0]`, active low, listed 0 to F: 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E. `seg[7]` = ~`dp[i]` unless the digit is dark.
- Guard interval: while `cnt` < `GUARD`, `an` = 4'hF and `seg` = 8'hFF. Otherwise `an` = ~(1<<`idx`) and `seg` shows the encoding of digit `idx`.
- Reset values:
  - Internal: `cnt` = 0, `idx` = 0, `fcnt` = 0, `bph` = 0, `pend_valid` = 0.
  - Active buffer: `blank` = 4'hF, all other fields 0.
  - Outputs: `seg` = 8'hFF, `an` = 4'hF, `frame_start` = 0.
- Reset mid-frame discards pending data. The display stays dark until the first load commits.

## Timing
- `seg`, `an` and `frame_start` are registered. Each reflects the internal state of the previous cycle (1-cycle latency).
- `frame_start` is high on exactly the cycle where the output first reflects `idx` = 0, `cnt` = 0 of a new frame. It is not asserted for the first frame after reset.
- Frame length: 4·`REFRESH_DIV` cycles. Blink full period: 2·`BLINK_FRAMES` frames.
- Load-to-display latency: from the load, up to one frame plus `GUARD` + 1 cycles until the digit is visible.
- `an` never shows two low bits, including across the slot change, because the guard covers every slot edge when `GUARD` ≥ 1.

## Test plan
All scenarios use `REFRESH_DIV` = 8, `GUARD` = 2, `BLINK_FRAMES` = 2.

- **Reset:** assert `rst` for 3 cycles. Expect `seg` = FF, `an` = F, `frame_start` = 0 throughout, and dark display through the first full frame.
- **Basic load and scan:** load `digits` = 16'h3A10, `blank` = 0, `dp` = 4'b0100. After the next frame boundary, expect:
  - Slot 0: `an` = E, `seg` = C0.
  - Slot 1: `an` = D, `seg` = F9.
  - Slot 2: `an` = B, `seg` = 08 (DP lit).
  - Slot 3: `an` = 7, `seg` = B0.
  - Each slot is preceded by 2 cycles of `an` = F.
- **Tear-free update:** load 16'h1111 mid-frame, then load 16'h8888 before the boundary. The current frame is unchanged, and the next frame shows all `seg` = 80 (last load wins).
- **Load coincident with boundary:** hold `load` on the wrap cycle with new data. The previously pending data shows in this frame and the new data in the following frame.
- **Blink:** set `blink` = 4'b0001. Digit 0 is lit for 2 frames, dark (`seg` = FF with `an` = E) for 2 frames, then repeats. Other digits are unaffected.
- **Mid-frame reset:** assert `rst` during slot 2 with a load pending. Expect outputs FF/F, and the pending data never appears.
